// File: rtl/fb_rect_writer.sv
// fb_rect_writer: write-side master of the pixel frame memory.
// Accepts rectangle-fill commands, clips them to the frame, then walks the rectangle in raster
// order and writes one pixel per SRAM cycle: address/data setup, active-low strobe, data hold.
// The bus is only used while the display path grants it. A write whose strobe has started is
// always completed.
//
// Ports:
//   clk, reset          system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake (ready only in IDLE)
//   cmd_x, cmd_y        top-left corner
//   cmd_w, cmd_h        extent in pixels (0..2**bits)
//   cmd_color           16-bit fill colour
//   mem_grant           display path releases the bus this cycle
//   addr                frame memory address {y, x}
//   pixel_color         write data
//   data_oe             drive pixel_color onto the shared bus
//   write_memory        active-low write strobe (registered, glitch-free)
//   busy                command in progress
//   done                one-cycle pulse after the last pixel's hold cycle
//   pix_count           pixels written for the current/last command
module fb_rect_writer #(
  parameter int unsigned X_BITS     = 8,
  parameter int unsigned Y_BITS     = 8,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [X_BITS-1:0] cmd_x,
  input  logic [Y_BITS-1:0] cmd_y,
  input  logic [X_BITS:0]   cmd_w,
  input  logic [Y_BITS:0]   cmd_h,
  input  logic [15:0]       cmd_color,
  input  logic              mem_grant,
  output logic [15:0]       addr,
  output logic [15:0]       pixel_color,
  output logic              data_oe,
  output logic              write_memory,
  output logic              busy,
  output logic              done,
  output logic [16:0]       pix_count
);

  typedef enum logic [2:0] {
    StIdle, StClip, StWait, StSetup, StStrobe, StHold, StDone
  } state_e;

  localparam logic [X_BITS:0] FRAME_W     = {1'b1, {X_BITS{1'b0}}};
  localparam logic [Y_BITS:0] FRAME_H     = {1'b1, {Y_BITS{1'b0}}};
  localparam logic [7:0]      SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0]      STROBE_LAST = 8'(STROBE_CYC - 1);

  state_e            state;
  logic [X_BITS-1:0] lat_x;
  logic [Y_BITS-1:0] lat_y;
  logic [X_BITS:0]   lat_w;
  logic [Y_BITS:0]   lat_h;
  logic [15:0]       lat_color;
  logic [X_BITS:0]   x_end;
  logic [Y_BITS:0]   y_end;
  logic [X_BITS-1:0] cur_x;
  logic [Y_BITS-1:0] cur_y;
  logic [7:0]        cnt;

  // Clipping: one extra bit holds x+w without wrap, then saturate at the frame edge.
  logic [X_BITS:0] x_sum, x_end_c;
  logic [Y_BITS:0] y_sum, y_end_c;
  logic            empty_rect;

  always_comb begin
    x_sum      = {1'b0, lat_x} + lat_w;
    y_sum      = {1'b0, lat_y} + lat_h;
    x_end_c    = (x_sum > FRAME_W) ? FRAME_W : x_sum;
    y_end_c    = (y_sum > FRAME_H) ? FRAME_H : y_sum;
    empty_rect = (lat_w == '0) || (lat_h == '0);
  end

  // Raster advance evaluated in HOLD.
  logic [X_BITS:0]   x_inc;
  logic [Y_BITS:0]   y_inc;
  logic              row_wrap, last_pix;
  logic [X_BITS-1:0] nxt_x;
  logic [Y_BITS-1:0] nxt_y;

  always_comb begin
    x_inc    = {1'b0, cur_x} + 1'b1;
    y_inc    = {1'b0, cur_y} + 1'b1;
    row_wrap = (x_inc == x_end);
    last_pix = row_wrap && (y_inc == y_end);
    nxt_x    = row_wrap ? lat_x : x_inc[X_BITS-1:0];
    nxt_y    = row_wrap ? y_inc[Y_BITS-1:0] : cur_y;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= StIdle;
      cmd_ready    <= 1'b0;
      addr         <= '0;
      pixel_color  <= '0;
      data_oe      <= 1'b0;
      write_memory <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      pix_count    <= '0;
      lat_x        <= '0;
      lat_y        <= '0;
      lat_w        <= '0;
      lat_h        <= '0;
      lat_color    <= '0;
      x_end        <= '0;
      y_end        <= '0;
      cur_x        <= '0;
      cur_y        <= '0;
      cnt          <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            lat_x     <= cmd_x;
            lat_y     <= cmd_y;
            lat_w     <= cmd_w;
            lat_h     <= cmd_h;
            lat_color <= cmd_color;
            pix_count <= '0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= StClip;
          end
        end
        StClip: begin
          x_end <= x_end_c;
          y_end <= y_end_c;
          if (empty_rect) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= StDone;
          end else begin
            cur_x <= lat_x;
            cur_y <= lat_y;
            state <= StWait;
          end
        end
        StWait: begin
          data_oe      <= 1'b0;
          write_memory <= 1'b1;
          if (mem_grant) begin
            addr        <= {cur_y, cur_x};
            pixel_color <= lat_color;
            data_oe     <= 1'b1;
            cnt         <= '0;
            state       <= StSetup;
          end
        end
        StSetup: begin
          if (!mem_grant) begin
            // Lost the bus before the strobe: back off, pixel retried later.
            data_oe <= 1'b0;
            state   <= StWait;
          end else if (cnt == SETUP_LAST) begin
            write_memory <= 1'b0;
            cnt          <= '0;
            state        <= StStrobe;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StStrobe: begin
          // Grant is deliberately ignored so a started write is never torn.
          if (cnt == STROBE_LAST) begin
            write_memory <= 1'b1;
            pix_count    <= pix_count + 1'b1;
            state        <= StHold;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StHold: begin
          cur_x <= nxt_x;
          cur_y <= nxt_y;
          if (last_pix) begin
            data_oe <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= StDone;
          end else if (mem_grant) begin
            addr  <= {nxt_y, nxt_x};
            cnt   <= '0;
            state <= StSetup;
          end else begin
            data_oe <= 1'b0;
            state   <= StWait;
          end
        end
        StDone: begin
          done      <= 1'b0;
          data_oe   <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
module tb_fb_rect_writer;

  localparam int STROBE_CYC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_x, cmd_y;
  logic [8:0]  cmd_w, cmd_h;
  logic [15:0] cmd_color;
  logic        mem_grant;
  logic [15:0] addr, pixel_color;
  logic        data_oe, write_memory, busy, done;
  logic [16:0] pix_count;

  always #5 clk = ~clk;

  fb_rect_writer dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_x        (cmd_x),
    .cmd_y        (cmd_y),
    .cmd_w        (cmd_w),
    .cmd_h        (cmd_h),
    .cmd_color    (cmd_color),
    .mem_grant    (mem_grant),
    .addr         (addr),
    .pixel_color  (pixel_color),
    .data_oe      (data_oe),
    .write_memory (write_memory),
    .busy         (busy),
    .done         (done),
    .pix_count    (pix_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard of expected writes {addr, data}, plus a model of memory contents.
  logic [31:0] exp_q[$];
  logic [15:0] mem[logic [15:0]];
  int          writes = 0;
  bit          toggle_grant = 0;

  // Strobe monitor: records each completed write and checks strobe shape.
  bit          prev_low = 0;
  int          low_cnt;
  logic [15:0] fa, fd;
  bit          stable, oe_ok;

  always @(negedge clk) begin
    if (!reset) begin
      prev_low = 0;
    end else if (write_memory === 1'b0) begin
      if (!prev_low) begin
        fa = addr; fd = pixel_color; low_cnt = 0; stable = 1; oe_ok = 1;
      end
      low_cnt++;
      if (addr !== fa || pixel_color !== fd) stable = 0;
      if (data_oe !== 1'b1) oe_ok = 0;
      prev_low = 1;
    end else if (prev_low) begin
      prev_low = 0;
      writes++;
      mem[fa] = fd;
      check_eq("strobe_len", low_cnt, STROBE_CYC);
      check_eq("strobe_stable", {31'd0, stable}, 1);
      check_eq("strobe_oe", {31'd0, oe_ok}, 1);
      check_eq("hold_oe", {31'd0, data_oe}, 1);
      check_eq("hold_addr", {16'd0, addr}, {16'd0, fa});
      check_eq("sb_nonempty", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) check_eq("write", {fa, fd}, exp_q.pop_front());
    end
  end

  task automatic push_expected(input int x, input int y, input int w, input int h,
                               input logic [15:0] color);
    for (int yy = y; yy < y + h && yy < 256; yy++)
      for (int xx = x; xx < x + w && xx < 256; xx++)
        exp_q.push_back({yy[7:0], xx[7:0], color});
  endtask

  task automatic start_cmd(input int x, input int y, input int w, input int h,
                           input logic [15:0] color);
    int n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_before_cmd", {31'd0, cmd_ready}, 1);
    mem.delete();
    push_expected(x, y, w, h, color);
    cmd_x = x[7:0]; cmd_y = y[7:0]; cmd_w = w[8:0]; cmd_h = h[8:0]; cmd_color = color;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Counts negedges after the accepting edge up to and including the done pulse; also
  // predicts what each SETUP cycle must lead to given the grant driven during it.
  task automatic wait_done(output int cycles);
    bit seen = 0, prev_setup = 0, prev_g = 1, prev_we = 1;
    cycles = 0;
    while (!seen && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (done === 1'b1) seen = 1;
      if (prev_setup) begin
        if (!prev_g) begin
          check_eq("setup_drop_oe", {31'd0, data_oe}, 0);
          check_eq("setup_drop_we", {31'd0, write_memory}, 1);
        end else begin
          check_eq("setup_go_we", {31'd0, write_memory}, 0);
        end
      end
      prev_setup = (data_oe === 1'b1) && (write_memory === 1'b1) && prev_we;
      mem_grant  = toggle_grant ? ((cycles / 3) % 2 == 0) : 1'b1;
      prev_g     = mem_grant;
      prev_we    = (write_memory === 1'b1);
    end
    check_eq("done_seen", {31'd0, seen}, 1);
  endtask

  int cyc, w0;

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; mem_grant = 1'b1;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    #3;
    repeat (2) @(negedge clk);
    check_eq("rst_addr", {16'd0, addr}, 0);
    check_eq("rst_data", {16'd0, pixel_color}, 0);
    check_eq("rst_oe", {31'd0, data_oe}, 0);
    check_eq("rst_we", {31'd0, write_memory}, 1);
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_done", {31'd0, done}, 0);
    check_eq("rst_ready", {31'd0, cmd_ready}, 0);
    check_eq("rst_pix", {15'd0, pix_count}, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_rst", {31'd0, cmd_ready}, 1);

    // Single pixel.
    w0 = writes;
    start_cmd(5, 3, 1, 1, 16'hF800);
    check_eq("busy_after_accept", {31'd0, busy}, 1);
    check_eq("ready_low_busy", {31'd0, cmd_ready}, 0);
    wait_done(cyc);
    check_eq("single_cycles", cyc, 7);
    check_eq("single_pix", {15'd0, pix_count}, 1);
    check_eq("single_writes", writes - w0, 1);
    check_eq("single_mem", {16'd0, mem[16'h0305]}, 32'h0000F800);
    check_eq("done_busy", {31'd0, busy}, 0);

    // Right-edge clip.
    w0 = writes;
    start_cmd(254, 10, 3, 2, 16'h07E0);
    wait_done(cyc);
    check_eq("clip_cycles", cyc, 4 * 4 + 3);
    check_eq("clip_pix", {15'd0, pix_count}, 4);
    check_eq("clip_writes", writes - w0, 4);
    check_eq("clip_no_col0", {31'd0, mem.exists(16'h0A00)}, 0);
    check_eq("clip_sb_empty", exp_q.size(), 0);

    // Empty rectangles.
    w0 = writes;
    start_cmd(10, 10, 0, 5, 16'h1234);
    wait_done(cyc);
    check_eq("w0_cycles", cyc, 2);
    check_eq("w0_pix", {15'd0, pix_count}, 0);
    start_cmd(10, 10, 5, 0, 16'h1234);
    wait_done(cyc);
    check_eq("h0_cycles", cyc, 2);
    check_eq("h0_pix", {15'd0, pix_count}, 0);
    check_eq("empty_writes", writes - w0, 0);

    // Toggling grant.
    w0 = writes;
    toggle_grant = 1;
    start_cmd(100, 20, 4, 1, 16'h001F);
    wait_done(cyc);
    toggle_grant = 0;
    mem_grant = 1'b1;
    check_eq("tog_pix", {15'd0, pix_count}, 4);
    check_eq("tog_writes", writes - w0, 4);
    check_eq("tog_mem_size", mem.size(), 4);
    check_eq("tog_mem_last", {16'd0, mem[16'h1467]}, 32'h0000001F);
    check_eq("tog_sb_empty", exp_q.size(), 0);

    // Asynchronous reset during the 2nd pixel's strobe.
    w0 = writes;
    start_cmd(40, 40, 4, 4, 16'h5555);
    cyc = 0;
    while (!(writes == w0 + 1 && write_memory === 1'b0) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("abort_reached", {31'd0, writes == w0 + 1 && write_memory === 1'b0}, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("abort_we", {31'd0, write_memory}, 1);
    check_eq("abort_oe", {31'd0, data_oe}, 0);
    exp_q.delete();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_ready", {31'd0, cmd_ready}, 1);
    repeat (20) @(negedge clk);
    check_eq("abort_writes", writes - w0, 1);
    check_eq("abort_mem", mem.size(), 1);

    // Back-to-back: valid held through busy.
    w0 = writes;
    start_cmd(1, 1, 2, 1, 16'h0F0F);
    cmd_valid = 1'b1;
    push_expected(1, 1, 2, 1, 16'h0F0F);
    wait_done(cyc);
    check_eq("b2b_ready_in_done", {31'd0, cmd_ready}, 0);
    @(negedge clk);
    check_eq("b2b_ready_idle", {31'd0, cmd_ready}, 1);
    check_eq("b2b_idle_busy", {31'd0, busy}, 0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check_eq("b2b_second_busy", {31'd0, busy}, 1);
    wait_done(cyc);
    check_eq("b2b_pix", {15'd0, pix_count}, 2);
    check_eq("b2b_writes", writes - w0, 4);

    // Full-width row at the bottom edge (w=256, bottom clip) and a larger block.
    start_cmd(0, 255, 256, 4, 16'hABCD);
    wait_done(cyc);
    check_eq("row_cycles", cyc, 256 * 4 + 3);
    check_eq("row_pix", {15'd0, pix_count}, 256);
    start_cmd(16, 16, 32, 16, 16'h2468);
    wait_done(cyc);
    check_eq("blk_cycles", cyc, 512 * 4 + 3);
    check_eq("blk_pix", {15'd0, pix_count}, 512);
    check_eq("blk_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
